// File: rtl/zvc_pkg.sv
// Shared definitions for the zero-value compressor scheduler: line geometry,
// compressor latency and the scheduler FSM encoding.
package zvc_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int DIST_WIDTH    = 4;
  localparam int MAX_LIFM_RSIZ = 5;
  localparam int LINE_WORDS    = 128;

  // Compressed LIFM words plus the compressed mapping table.
  localparam int ZVC_DATA_W   = LINE_WORDS * WORD_WIDTH + LINE_WORDS * DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int ZVC_CNT_W    = $clog2(LINE_WORDS + 1);
  localparam int ZVC_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } zvc_state_t;

endpackage

// File: rtl/zvc_out_fifo.sv
// Shift-style skid FIFO: entry 0 is always the head, so the head is a plain
// register. Synchronous clear empties it in one cycle.
module zvc_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic             full, pop_eff, push_eff;
  logic [CNT_W-1:0] wr_idx, count_nxt;

  assign full     = (count == CNT_W'(DEPTH));
  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && (!full || pop_eff);
  // A simultaneous pop moves the tail down one slot before the write lands.
  assign wr_idx   = pop_eff ? (count - CNT_W'(1)) : count;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) shifted[i] = mem[i+1];
    shifted[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = pop_eff ? shifted[i] : mem[i];
      if (push_eff && (wr_idx == CNT_W'(i))) mem_nxt[i] = push_data;
    end
    count_nxt = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_nxt;
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
    end
  end

  assign head = mem[0];

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop_eff));

endmodule

// File: rtl/zvc_comp_scheduler.sv
// Issues one tile of lines into the fixed-latency, non-stallable compressor and
// uses credits so every compressor result always has a skid FIFO slot waiting.
module zvc_comp_scheduler
  import zvc_pkg::*;
#(
  parameter int DATA_W     = ZVC_DATA_W,
  parameter int CNT_W      = ZVC_CNT_W,
  parameter int LINE_CNT_W = 16,
  parameter int PIPE_LAT   = ZVC_PIPE_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [LINE_CNT_W-1:0] num_lines,
  output logic                  busy,
  output logic                  tile_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNT_W-1:0]      in_nz_cnt,
  output logic                  zvc_issue,
  input  logic [DATA_W-1:0]     zvc_comp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CNT_W-1:0]      out_nz_cnt,
  output logic                  out_last,
  output zvc_state_t            fsm_state
);

  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
  localparam int ENTRY_W = DATA_W + CNT_W + 1;

  zvc_state_t            state, state_nxt;
  logic [LINE_CNT_W-1:0] num_lines_q, issued_cnt;
  logic [PIPE_LAT-1:0]   v_pipe, last_pipe;
  logic [CNT_W-1:0]      nz_pipe [PIPE_LAT];
  logic [FCNT_W-1:0]     fifo_count;
  logic [OCC_W-1:0]      inflight, occupancy;
  logic [ENTRY_W-1:0]    head;
  logic                  is_last, out_fire, done_set;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + OCC_W'(v_pipe[i]);
  end

  // Handshakes: a transfer happens on a cycle where valid && ready. Valid never
  // depends on ready; in_ready depends only on registered credit state.
  assign occupancy = OCC_W'(fifo_count) + inflight;
  assign in_ready  = (state == ST_RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign zvc_issue = in_valid && in_ready;
  assign is_last   = (issued_cnt == num_lines_q - LINE_CNT_W'(1));
  assign out_valid = (fifo_count != '0);
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;
  assign {out_data, out_nz_cnt, out_last} = head;

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_lines != '0) state_nxt = ST_RUN;
          else                 done_set  = 1'b1;
        end
      end
      ST_RUN:   if (zvc_issue && is_last) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (out_fire && out_last) begin
          state_nxt = ST_IDLE;
          done_set  = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      done_set  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      tile_done   <= 1'b0;
      num_lines_q <= '0;
      issued_cnt  <= '0;
      v_pipe      <= '0;
      last_pipe   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) nz_pipe[i] <= '0;
    end else begin
      state     <= state_nxt;
      tile_done <= done_set;
      if (flush) begin
        // Clearing the valid bits drops whatever is still inside the compressor.
        issued_cnt <= '0;
        v_pipe     <= '0;
        last_pipe  <= '0;
      end else begin
        if ((state == ST_IDLE) && start) begin
          num_lines_q <= num_lines;
          issued_cnt  <= '0;
        end else if (zvc_issue) begin
          issued_cnt <= issued_cnt + LINE_CNT_W'(1);
        end
        v_pipe[0]    <= zvc_issue;
        last_pipe[0] <= zvc_issue && is_last;
        nz_pipe[0]   <= in_nz_cnt;
        for (int i = 1; i < PIPE_LAT; i++) begin
          v_pipe[i]    <= v_pipe[i-1];
          last_pipe[i] <= last_pipe[i-1];
          nz_pipe[i]   <= nz_pipe[i-1];
        end
      end
    end
  end

  zvc_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (reset),
    .clear     (flush),
    .push      (v_pipe[PIPE_LAT-1]),
    .push_data ({zvc_comp, nz_pipe[PIPE_LAT-1], last_pipe[PIPE_LAT-1]}),
    .pop       (out_ready),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_zvc_comp_scheduler.sv
// Randomized bench for zvc_comp_scheduler: a driver models credits, latency and
// tile bookkeeping; a monitor pops expected lines as the DUT delivers them.
`timescale 1ns/1ps
module tb_zvc_comp_scheduler;
  import zvc_pkg::*;

  localparam int DATA_W     = ZVC_DATA_W;
  localparam int CNT_W      = ZVC_CNT_W;
  localparam int LINE_CNT_W = 16;
  localparam int PIPE_LAT   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = DATA_W + CNT_W + 1;

  logic                  clk, reset, start, flush;
  logic [LINE_CNT_W-1:0] num_lines;
  logic                  busy, tile_done, in_valid, in_ready, zvc_issue;
  logic [CNT_W-1:0]      in_nz_cnt, out_nz_cnt;
  logic [DATA_W-1:0]     zvc_comp, out_data;
  logic                  out_valid, out_ready, out_last;
  zvc_state_t            fsm_state;

  zvc_comp_scheduler #(
    .DATA_W (DATA_W), .CNT_W (CNT_W), .LINE_CNT_W (LINE_CNT_W),
    .PIPE_LAT (PIPE_LAT), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .flush (flush),
    .num_lines (num_lines), .busy (busy), .tile_done (tile_done),
    .in_valid (in_valid), .in_ready (in_ready), .in_nz_cnt (in_nz_cnt),
    .zvc_issue (zvc_issue), .zvc_comp (zvc_comp),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_nz_cnt (out_nz_cnt), .out_last (out_last), .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int avail_q[$];
  int cyc = 0;
  bit run_m, busy_model, busy_set, flush_pend, done_arm, done_due, exp_issue, nz_seq;
  int n_m, acc_cnt, del_cnt;
  int issue_seen, done_seen, out_seen;
  logic [DATA_W-1:0] sched_d [4];
  bit sched_v [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    avail_q.delete();
    run_m = 0; busy_model = 0; busy_set = 0; flush_pend = 0;
    done_arm = 0; done_due = 0; exp_issue = 0;
    n_m = 0; acc_cnt = 0; del_cnt = 0;
    for (int i = 0; i < 4; i++) sched_v[i] = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit v, input bit rdy, input bit st, input bit fl, input int n);
    int slot;
    bit exp_ready;
    logic [DATA_W-1:0] d;
    @(posedge clk); #1;
    cyc++;
    // The compressor answers exactly PIPE_LAT cycles after an issue; junk otherwise.
    slot = cyc % 4;
    if (sched_v[slot]) begin
      zvc_comp = sched_d[slot];
      sched_v[slot] = 0;
    end else begin
      zvc_comp = rand_word();
    end
    exp_ready = run_m && (acc_cnt < n_m) && (acc_cnt - del_cnt < FIFO_DEPTH);
    chk("in_ready", in_ready, exp_ready);
    in_valid  = v;
    in_nz_cnt = nz_seq ? CNT_W'(acc_cnt + 1) : CNT_W'($urandom_range(0, 128));
    out_ready = rdy;
    start     = st;
    flush     = fl;
    num_lines = LINE_CNT_W'(n);
    exp_issue = v && exp_ready;
    if (fl) begin
      run_m = 0; acc_cnt = 0; del_cnt = 0; flush_pend = 1;
      for (int i = 0; i < 4; i++) sched_v[i] = 0;
    end else begin
      if (exp_issue) begin
        d = rand_word();
        exp_q.push_back({d, in_nz_cnt, (acc_cnt == n_m - 1)});
        avail_q.push_back(cyc + PIPE_LAT + 1);
        sched_d[(cyc + PIPE_LAT) % 4] = d;
        sched_v[(cyc + PIPE_LAT) % 4] = 1;
        acc_cnt++;
        if (acc_cnt == n_m) run_m = 0;
      end
      if (st && !busy_model) begin
        if (n == 0) done_arm = 1;
        else begin
          run_m = 1; n_m = n; acc_cnt = 0; del_cnt = 0; busy_set = 1;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (!reset) begin
      chk("zvc_issue", zvc_issue, exp_issue);
      chk("tile_done", tile_done, done_due);
      chk("busy", busy, busy_model);
      chk("out_valid", out_valid, (avail_q.size() > 0) && (avail_q[0] <= cyc));
      if (zvc_issue) issue_seen++;
      if (tile_done) done_seen++;
      done_due = done_arm;
      done_arm = 0;
      if (out_valid && out_ready) begin
        out_seen++;
        chk("output_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          void'(avail_q.pop_front());
          checks++;
          if (out_data !== e[W-1 -: DATA_W]) begin
            errors++;
            $display("FAIL out_data: got ..%h, expected ..%h (cycle %0d)", out_data[63:0], e[CNT_W+64:CNT_W+1], cyc);
          end
          chk("out_nz_cnt", out_nz_cnt, e[CNT_W:1]);
          chk("out_last", out_last, e[0]);
          if (e[0]) begin
            done_due = 1;
            busy_model = 0;
          end
          del_cnt++;
        end
      end
      if (busy_set) busy_model = 1;
      busy_set = 0;
      if (flush_pend) begin
        exp_q.delete();
        avail_q.delete();
        busy_model = 0;
        flush_pend = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int i0, d0, o0, k;

  initial begin
    reset = 1; start = 0; flush = 0; num_lines = '0; in_valid = 0;
    in_nz_cnt = '0; zvc_comp = '0; out_ready = 0; nz_seq = 0;
    issue_seen = 0; done_seen = 0; out_seen = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_nz_cnt", out_nz_cnt, 0);
    chk("rst_out_data", 64'(|out_data), 0);
    chk("rst_state", fsm_state, ST_IDLE);
    @(posedge clk); #1;
    reset = 0;

    // Short tile, everything always ready.
    i0 = issue_seen; d0 = done_seen; o0 = out_seen;
    drive_cycle(1, 1, 1, 0, 3);
    repeat (10) drive_cycle(1, 1, 0, 0, 3);
    chk("t1_issues", issue_seen - i0, 3);
    chk("t1_outputs", out_seen - o0, 3);
    chk("t1_done", done_seen - d0, 1);
    chk("t1_busy", busy, 0);

    // Downstream stalled: credits stop issue at FIFO_DEPTH lines.
    nz_seq = 1;
    i0 = issue_seen; d0 = done_seen; o0 = out_seen;
    drive_cycle(1, 0, 1, 0, 8);
    repeat (12) drive_cycle(1, 0, 0, 0, 8);
    chk("t2_stalled_issues", issue_seen - i0, FIFO_DEPTH);
    repeat (30) drive_cycle(1, 1, 0, 0, 8);
    chk("t2_issues", issue_seen - i0, 8);
    chk("t2_outputs", out_seen - o0, 8);
    chk("t2_done", done_seen - d0, 1);
    nz_seq = 0;

    // Long tile with random valid and ready.
    i0 = issue_seen; d0 = done_seen; o0 = out_seen;
    drive_cycle(1, 1, 1, 0, 100);
    for (k = 0; k < 3000 && done_seen == d0; k++)
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 100);
    repeat (3) drive_cycle(0, 1, 0, 0, 0);
    chk("t3_done", done_seen - d0, 1);
    chk("t3_issues", issue_seen - i0, 100);
    chk("t3_outputs", out_seen - o0, 100);

    // Empty tile.
    i0 = issue_seen; d0 = done_seen;
    drive_cycle(1, 1, 1, 0, 0);
    repeat (4) drive_cycle(1, 1, 0, 0, 0);
    chk("t4_done", done_seen - d0, 1);
    chk("t4_issues", issue_seen - i0, 0);

    // Flush mid-tile, then a fresh tile.
    d0 = done_seen;
    drive_cycle(1, 1, 1, 0, 10);
    for (k = 0; k < 50 && acc_cnt < 5; k++) drive_cycle(1, 1, 0, 0, 10);
    drive_cycle(0, 1, 0, 0, 10);
    drive_cycle(0, 1, 0, 0, 10);
    drive_cycle(0, 0, 0, 1, 10);
    repeat (5) drive_cycle(0, 1, 0, 0, 0);
    chk("t5_no_done", done_seen - d0, 0);
    chk("t5_state", fsm_state, ST_IDLE);
    chk("t5_out_valid", out_valid, 0);
    d0 = done_seen; o0 = out_seen;
    drive_cycle(1, 1, 1, 0, 2);
    repeat (10) drive_cycle(1, 1, 0, 0, 2);
    chk("t5_restart_done", done_seen - d0, 1);
    chk("t5_restart_outputs", out_seen - o0, 2);

    // Asynchronous reset while draining with two lines buffered.
    drive_cycle(1, 0, 1, 0, 2);
    repeat (6) drive_cycle(1, 0, 0, 0, 2);
    chk("t6_state_drain", fsm_state, ST_DRAIN);
    chk("t6_out_valid_pre", out_valid, 1);
    reset = 1; in_valid = 0; out_ready = 0;
    clear_model();
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_tile_done", tile_done, 0);
    chk("t6_out_last", out_last, 0);
    chk("t6_out_nz_cnt", out_nz_cnt, 0);
    chk("t6_out_data", 64'(|out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("t6_post_state", fsm_state, ST_IDLE);
    chk("t6_post_in_ready", in_ready, 0);
    repeat (3) drive_cycle(0, 1, 0, 0, 0);
    d0 = done_seen;
    drive_cycle(1, 1, 1, 0, 1);
    repeat (6) drive_cycle(1, 1, 0, 0, 1);
    chk("t6_recover_done", done_seen - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
